// File: rtl/mpt_fetch_arbiter.sv
// rtl/mpt_fetch_arbiter.sv - round-robin MPT fetch arbiter with SPA format check and 2-entry output FIFO
// Optional per-channel saturating fault counters on err_cnt_o: define MPT_FETCH_ERR_CNT_EN.
module mpt_fetch_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int SPA_WIDTH = 64,
    parameter int TAG_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CH-1:0]             ch_valid_i,
    output logic [NUM_CH-1:0]             ch_ready_o,
    input  logic [NUM_CH*4-1:0]           ch_mode_i,
    input  logic [NUM_CH*SPA_WIDTH-1:0]   ch_spa_i,
    input  logic [NUM_CH*TAG_WIDTH-1:0]   ch_tag_i,
    input  logic                          flush_i,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [SPA_WIDTH-1:0]          m_spa_o,
    output logic [3:0]                    m_mode_o,
    output logic [TAG_WIDTH-1:0]          m_tag_o,
    output logic [$clog2(NUM_CH)-1:0]     m_ch_o,
    output logic                          m_walking_o,
    output logic [1:0]                    m_fault_o,
    output logic                          exc_valid_o,
    output logic [$clog2(NUM_CH)-1:0]     exc_ch_o,
    output logic [1:0]                    exc_cause_o
`ifdef MPT_FETCH_ERR_CNT_EN
    ,
    output logic [NUM_CH*CNT_WIDTH-1:0]   err_cnt_o
`endif
);
    localparam int CHW = $clog2(NUM_CH);

    typedef struct packed {
        logic [SPA_WIDTH-1:0] spa;
        logic [3:0]           mode;
        logic [TAG_WIDTH-1:0] tag;
        logic [CHW-1:0]       ch;
        logic                 walk;
        logic                 fault;
    } entry_t;

    logic [CHW-1:0]       rr_q;
    logic [CHW-1:0]       gidx;
    logic [CHW-1:0]       idx;
    logic                 any_valid;
    logic                 accept;
    logic                 pop;
    logic                 fault;
    logic [3:0]           g_mode;
    logic [SPA_WIDTH-1:0] g_spa;
    logic [1:0]           count_q;
    entry_t               ent_q [2];
    entry_t               new_ent;
    logic                 exc_valid_q;
    logic [CHW-1:0]       exc_ch_q;
    logic [1:0]           exc_cause_q;

    // Scan downward so the valid channel closest to rr_q is the last one written.
    always_comb begin
        any_valid = 1'b0;
        gidx      = '0;
        idx       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CHW'((int'(rr_q) + i) % NUM_CH);
            if (ch_valid_i[idx]) begin
                any_valid = 1'b1;
                gidx      = idx;
            end
        end
    end

    always_comb begin
        g_mode = ch_mode_i[gidx*4 +: 4];
        g_spa  = ch_spa_i[gidx*SPA_WIDTH +: SPA_WIDTH];
        case (g_mode)
            4'd1:    fault = |g_spa[63:43];
            4'd2:    fault = |g_spa[63:52];
            4'd3:    fault = 1'b0;
            default: fault = 1'b1;
        endcase
        new_ent.spa   = g_spa;
        new_ent.mode  = g_mode;
        new_ent.tag   = ch_tag_i[gidx*TAG_WIDTH +: TAG_WIDTH];
        new_ent.ch    = gidx;
        new_ent.walk  = !fault;
        new_ent.fault = fault;
        ch_ready_o = '0;
        if (any_valid && count_q != 2'd2 && !flush_i) begin
            ch_ready_o[gidx] = 1'b1;
        end
    end

    assign accept = |ch_ready_o;
    assign pop    = (count_q != 2'd0) && m_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q     <= '0;
            rr_q        <= '0;
            ent_q[0]    <= '0;
            ent_q[1]    <= '0;
            exc_valid_q <= 1'b0;
            exc_ch_q    <= '0;
            exc_cause_q <= '0;
        end else begin
            exc_valid_q <= accept && fault;
            if (accept) begin
                rr_q <= (int'(gidx) == NUM_CH - 1) ? '0 : gidx + 1'b1;
            end
            if (accept && fault) begin
                exc_ch_q    <= gidx;
                exc_cause_q <= 2'd1;
            end
            if (flush_i) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + {1'b0, accept} - {1'b0, pop};
                if (pop && count_q == 2'd2) begin
                    ent_q[0] <= ent_q[1];
                end
                // A full FIFO never accepts, so the shift above and a push never collide.
                if (accept) begin
                    if (count_q == 2'd0 || (pop && count_q == 2'd1)) begin
                        ent_q[0] <= new_ent;
                    end else begin
                        ent_q[1] <= new_ent;
                    end
                end
            end
        end
    end

    assign m_valid_o   = (count_q != 2'd0);
    assign m_spa_o     = ent_q[0].spa;
    assign m_mode_o    = ent_q[0].mode;
    assign m_tag_o     = ent_q[0].tag;
    assign m_ch_o      = ent_q[0].ch;
    assign m_walking_o = ent_q[0].walk;
    assign m_fault_o   = {1'b0, ent_q[0].fault};
    assign exc_valid_o = exc_valid_q;
    assign exc_ch_o    = exc_ch_q;
    assign exc_cause_o = exc_cause_q;

`ifdef MPT_FETCH_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (rst_i) begin
                cnt_q[k] <= '0;
            end else if (accept && fault && int'(gidx) == k && cnt_q[k] != '1) begin
                cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
        assign err_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
    end
`endif
endmodule

// File: tb/tb_mpt_fetch_arbiter.sv
// tb/tb_mpt_fetch_arbiter.sv - self-checking bench for mpt_fetch_arbiter with a queue-based reference model
module tb_mpt_fetch_arbiter;
    localparam int N = 4;
`ifdef MPT_FETCH_ERR_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   ch_valid_i;
    logic [N-1:0]   ch_ready_o;
    logic [N*4-1:0] ch_mode_i;
    logic [N*64-1:0] ch_spa_i;
    logic [N*8-1:0] ch_tag_i;
    logic           flush_i;
    logic           m_valid_o;
    logic           m_ready_i;
    logic [63:0]    m_spa_o;
    logic [3:0]     m_mode_o;
    logic [7:0]     m_tag_o;
    logic [1:0]     m_ch_o;
    logic           m_walking_o;
    logic [1:0]     m_fault_o;
    logic           exc_valid_o;
    logic [1:0]     exc_ch_o;
    logic [1:0]     exc_cause_o;
`ifdef MPT_FETCH_ERR_CNT_EN
    logic [N*CW-1:0] err_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] spa;
        logic [3:0]  mode;
        logic [7:0]  tag;
        int          ch;
        int          fault;
    } txn_t;

    txn_t q[$];
    int   rr = 0;
    bit   exp_exc = 0;
    int   exp_exc_ch = 0;
    int   exp_exc_cause = 0;

    mpt_fetch_arbiter #(.NUM_CH(N), .SPA_WIDTH(64), .TAG_WIDTH(8), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o),
        .ch_mode_i(ch_mode_i), .ch_spa_i(ch_spa_i), .ch_tag_i(ch_tag_i),
        .flush_i(flush_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_spa_o(m_spa_o), .m_mode_o(m_mode_o), .m_tag_o(m_tag_o),
        .m_ch_o(m_ch_o), .m_walking_o(m_walking_o), .m_fault_o(m_fault_o),
        .exc_valid_o(exc_valid_o), .exc_ch_o(exc_ch_o), .exc_cause_o(exc_cause_o)
`ifdef MPT_FETCH_ERR_CNT_EN
        , .err_cnt_o(err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic int ref_fault(logic [3:0] mode, logic [63:0] spa);
        case (mode)
            4'd1:    return ((spa >> 43) != 0) ? 1 : 0;
            4'd2:    return ((spa >> 52) != 0) ? 1 : 0;
            4'd3:    return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int ref_grant();
        if (flush_i || q.size() == 2) return -1;
        for (int i = 0; i < N; i++) begin
            if (ch_valid_i[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    // Advance one clock and apply the same step to the reference model.
    task automatic cycle();
        int   g;
        txn_t t;
        g = ref_grant();
        @(posedge clk_i);
        exp_exc = 0;
        if (rst_i) begin
            q.delete();
            rr = 0;
            exp_exc_ch = 0;
            exp_exc_cause = 0;
        end else if (flush_i) begin
            q.delete();
        end else begin
            if (q.size() > 0 && m_ready_i) void'(q.pop_front());
            if (g >= 0) begin
                t.spa   = ch_spa_i[g*64 +: 64];
                t.mode  = ch_mode_i[g*4 +: 4];
                t.tag   = ch_tag_i[g*8 +: 8];
                t.ch    = g;
                t.fault = ref_fault(t.mode, t.spa);
                q.push_back(t);
                rr = (g + 1) % N;
                if (t.fault != 0) begin
                    exp_exc = 1;
                    exp_exc_ch = g;
                    exp_exc_cause = 1;
                end
            end
        end
        #1;
    endtask

    task automatic set_ch(int k, logic [3:0] mode, logic [63:0] spa, logic [7:0] tag);
        ch_valid_i[k]         = 1'b1;
        ch_mode_i[k*4 +: 4]   = mode;
        ch_spa_i[k*64 +: 64]  = spa;
        ch_tag_i[k*8 +: 8]    = tag;
    endtask

    task automatic idle_inputs();
        ch_valid_i = '0;
        ch_mode_i  = '0;
        ch_spa_i   = '0;
        ch_tag_i   = '0;
        flush_i    = 1'b0;
        m_ready_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (m_valid_o !== 1'b0 || ch_ready_o !== 4'b0 || exc_valid_o !== 1'b0 || exc_ch_o !== 2'd0 || exc_cause_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: m_valid=%b ready=%b exc=%b ch=%0d cause=%0d, want all 0",
                     m_valid_o, ch_ready_o, exc_valid_o, exc_ch_o, exc_cause_o);
        end
        checks++;
        if (m_spa_o !== 64'd0 || m_tag_o !== 8'd0 || m_mode_o !== 4'd0 || m_ch_o !== 2'd0 || m_walking_o !== 1'b0 || m_fault_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: spa=%h tag=%h mode=%0d ch=%0d walk=%b fault=%0d, want all 0",
                     m_spa_o, m_tag_o, m_mode_o, m_ch_o, m_walking_o, m_fault_o);
        end
        set_ch(2, 4'd3, 64'hFFFF_0000_0000_1000, 8'h5A);
        #1;
        checks++;
        if (ch_ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL first_ready: got %b want 0100", ch_ready_o);
        end
        cycle();
        checks++;
        if (m_valid_o !== 1'b1 || m_ch_o !== 2'd2 || m_walking_o !== 1'b1 || m_fault_o !== 2'd0 ||
            m_spa_o !== 64'hFFFF_0000_0000_1000 || m_tag_o !== 8'h5A) begin
            errors++;
            $display("FAIL first_txn: valid=%b ch=%0d walk=%b fault=%0d spa=%h tag=%h, want 1/2/1/0/ffff000000001000/5a",
                     m_valid_o, m_ch_o, m_walking_o, m_fault_o, m_spa_o, m_tag_o);
        end
        checks++;
        if (exc_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_no_exc: exc_valid=%b want 0", exc_valid_o);
        end
        idle_inputs();
        m_ready_i = 1'b1;
        cycle();
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_pop: m_valid=%b want 0", m_valid_o);
        end
    endtask

    task automatic test_mode_checks();
        logic [3:0]  modes [6];
        logic [63:0] spas  [6];
        int          flt   [6];
        modes = '{4'd1, 4'd2, 4'd0, 4'd7, 4'd2, 4'd3};
        spas  = '{64'd1 << 43, 64'd1 << 52, 64'd0, 64'd0, 64'd1 << 51, 64'hFFFF_FFFF_FFFF_FFFF};
        flt   = '{1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            m_ready_i = 1'b1;
            set_ch(0, modes[i], spas[i], 8'(i));
            cycle();
            idle_inputs();
            m_ready_i = 1'b1;
            checks++;
            if (m_valid_o !== 1'b1 || m_ch_o !== 2'd0 || m_fault_o !== 2'(flt[i]) || m_walking_o !== (flt[i] == 0)) begin
                errors++;
                $display("FAIL mode_%0d: valid=%b ch=%0d fault=%0d walk=%b, want 1/0/%0d/%0d",
                         i, m_valid_o, m_ch_o, m_fault_o, m_walking_o, flt[i], flt[i] == 0);
            end
            checks++;
            if (exc_valid_o !== 1'(flt[i]) || (flt[i] == 1 && (exc_ch_o !== 2'd0 || exc_cause_o !== 2'd1))) begin
                errors++;
                $display("FAIL mode_exc_%0d: exc=%b ch=%0d cause=%0d, want exc=%0d ch=0 cause=1",
                         i, exc_valid_o, exc_ch_o, exc_cause_o, flt[i]);
            end
            cycle();
            checks++;
            if (exc_valid_o !== 1'b0 || m_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL mode_after_%0d: exc=%b valid=%b, want 0/0", i, exc_valid_o, m_valid_o);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        m_ready_i = 1'b1;
        for (int k = 0; k < N; k++) set_ch(k, 4'd3, 64'(k) << 12, 8'(k));
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (ch_ready_o !== 4'(1 << (i % N))) begin
                errors++;
                $display("FAIL rr_ready_%0d: got %b want %b", i, ch_ready_o, 4'(1 << (i % N)));
            end
            cycle();
            checks++;
            if (m_valid_o !== 1'b1 || m_ch_o !== 2'(i % N) || m_tag_o !== 8'(i % N)) begin
                errors++;
                $display("FAIL rr_out_%0d: valid=%b ch=%0d tag=%0d want 1/%0d/%0d", i, m_valid_o, m_ch_o, m_tag_o, i % N, i % N);
            end
        end
        idle_inputs();
        m_ready_i = 1'b1;
        cycle();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_ch(1, 4'd3, 64'h100, 8'h11);
        set_ch(3, 4'd3, 64'h300, 8'h33);
        #1;
        checks++;
        if (ch_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_ready0: got %b want 0010", ch_ready_o); end
        cycle();
        checks++;
        if (ch_ready_o !== 4'b1000) begin errors++; $display("FAIL bp_ready1: got %b want 1000", ch_ready_o); end
        cycle();
        cycle();
        checks++;
        if (ch_ready_o !== 4'b0000 || m_valid_o !== 1'b1 || m_ch_o !== 2'd1) begin
            errors++;
            $display("FAIL bp_full: ready=%b valid=%b ch=%0d want 0000/1/1", ch_ready_o, m_valid_o, m_ch_o);
        end
        idle_inputs();
        m_ready_i = 1'b1;
        cycle();
        checks++;
        if (m_valid_o !== 1'b1 || m_ch_o !== 2'd3 || m_tag_o !== 8'h33) begin
            errors++;
            $display("FAIL bp_pop2: valid=%b ch=%0d tag=%h want 1/3/33", m_valid_o, m_ch_o, m_tag_o);
        end
        cycle();
        checks++;
        if (m_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: valid=%b want 0", m_valid_o); end
    endtask

    task automatic test_flush();
        do_reset();
        set_ch(1, 4'd3, 64'h0, 8'h11);
        set_ch(3, 4'd3, 64'h0, 8'h33);
        cycle();
        cycle();
        idle_inputs();
        set_ch(0, 4'd0, 64'h0, 8'hF0);
        flush_i = 1'b1;
        #1;
        checks++;
        if (ch_ready_o !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b want 0000", ch_ready_o); end
        cycle();
        flush_i = 1'b0;
        checks++;
        if (m_valid_o !== 1'b0 || exc_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_out: valid=%b exc=%b want 0/0", m_valid_o, exc_valid_o);
        end
        #1;
        checks++;
        if (ch_ready_o !== 4'b0001) begin errors++; $display("FAIL flush_after_ready: got %b want 0001", ch_ready_o); end
        cycle();
        checks++;
        if (m_valid_o !== 1'b1 || m_ch_o !== 2'd0 || m_fault_o !== 2'd1 || exc_valid_o !== 1'b1 || exc_ch_o !== 2'd0) begin
            errors++;
            $display("FAIL flush_accept: valid=%b ch=%0d fault=%0d exc=%b exc_ch=%0d want 1/0/1/1/0",
                     m_valid_o, m_ch_o, m_fault_o, exc_valid_o, exc_ch_o);
        end
        idle_inputs();
        m_ready_i = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        int         g;
        logic [3:0] exp_ready;
        do_reset();
        for (int it = 0; it < 600; it++) begin
            rst_i      = ($urandom_range(0, 99) == 0);
            flush_i    = ($urandom_range(0, 19) == 0);
            m_ready_i  = ($urandom_range(0, 9) < 7);
            ch_valid_i = 4'($urandom);
            for (int k = 0; k < N; k++) begin
                ch_mode_i[k*4 +: 4]  = 4'($urandom_range(0, 5));
                ch_spa_i[k*64 +: 64] = {$urandom, $urandom} >> $urandom_range(0, 63);
                ch_tag_i[k*8 +: 8]   = 8'($urandom);
            end
            #1;
            g = ref_grant();
            exp_ready = (g < 0) ? 4'b0 : 4'(1 << g);
            if (!rst_i) begin
                checks++;
                if (ch_ready_o !== exp_ready) begin
                    errors++;
                    $display("FAIL rand_ready it=%0d: got %b want %b", it, ch_ready_o, exp_ready);
                end
            end
            cycle();
            checks++;
            if (m_valid_o !== (q.size() > 0)) begin
                errors++;
                $display("FAIL rand_valid it=%0d: got %b want %0d", it, m_valid_o, q.size() > 0);
            end
            if (q.size() > 0) begin
                checks++;
                if (m_spa_o !== q[0].spa || m_mode_o !== q[0].mode || m_tag_o !== q[0].tag || m_ch_o !== 2'(q[0].ch) ||
                    m_fault_o !== 2'(q[0].fault) || m_walking_o !== (q[0].fault == 0)) begin
                    errors++;
                    $display("FAIL rand_head it=%0d: spa=%h mode=%0d tag=%h ch=%0d fault=%0d walk=%b want %h/%0d/%h/%0d/%0d",
                             it, m_spa_o, m_mode_o, m_tag_o, m_ch_o, m_fault_o, m_walking_o,
                             q[0].spa, q[0].mode, q[0].tag, q[0].ch, q[0].fault);
                end
            end
            checks++;
            if (exc_valid_o !== exp_exc || exc_ch_o !== 2'(exp_exc_ch) || exc_cause_o !== 2'(exp_exc_cause)) begin
                errors++;
                $display("FAIL rand_exc it=%0d: exc=%b ch=%0d cause=%0d want %0d/%0d/%0d",
                         it, exc_valid_o, exc_ch_o, exc_cause_o, exp_exc, exp_exc_ch, exp_exc_cause);
            end
        end
        rst_i = 1'b0;
    endtask

`ifdef MPT_FETCH_ERR_CNT_EN
    task automatic test_err_cnt();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            m_ready_i = 1'b1;
            set_ch(1, 4'd0, 64'h0, 8'(i));
            cycle();
        end
        idle_inputs();
        cycle();
        checks++;
        if (err_cnt_o !== 8'b0000_1100) begin
            errors++;
            $display("FAIL err_cnt: got %b want 00001100", err_cnt_o);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        test_reset();
        test_mode_checks();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_random();
`ifdef MPT_FETCH_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mpt_fetch_arbiter.md
# mpt_fetch_arbiter

Multi-channel, parametrised successor to the single-port MPT fetch stage. It arbitrates NUM_CH independent requesters round-robin and checks the supervisor physical address format of the granted transaction against its SMMPT mode. It tags each transaction with the walk/skip decision, fault cause and source channel, and buffers it in a 2-entry output FIFO. It sits at the head of the MPT walk pipeline, between the requesting ports and the first walk stage.

## Interface
- NUM_CH, 4: number of requester channels (2..16).
- SPA_WIDTH, 64: SPA width in bits (fixed at 64 for mode checks).
- TAG_WIDTH, 8: opaque per-transaction tag carried unchanged.
- CNT_WIDTH, 16: per-channel fault counter width (used only with MPT_FETCH_ERR_CNT_EN).

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- ch_valid_i  in  NUM_CH  per-channel request valid.
- ch_ready_o  out  NUM_CH  per-channel accept; at most one bit high.
- ch_mode_i  in  NUM_CH*4  per-channel MMPT MODE field.
- ch_spa_i  in  NUM_CH*SPA_WIDTH  per-channel SPA.
- ch_tag_i  in  NUM_CH*TAG_WIDTH  per-channel tag.
- flush_i  in  1  discard all buffered transactions.
- m_valid_o / m_ready_i  out / in  1 / 1  master handshake.
- m_spa_o, m_mode_o, m_tag_o  out  SPA_WIDTH, 4, TAG_WIDTH  forwarded fields.
- m_ch_o  out  $clog2(NUM_CH)  source channel index.
- m_walking_o  out  1  1 = walk, 0 = skip (fault).
- m_fault_o  out  2  0 = NO_ERROR, 1 = NOT_VALID_ADDR.
- exc_valid_o  out  1  one-cycle fault pulse.
- exc_ch_o  out  $clog2(NUM_CH)  faulting channel.
- exc_cause_o  out  2  fault cause.
- err_cnt_o  out  NUM_CH*CNT_WIDTH  saturating fault counters (MPT_FETCH_ERR_CNT_EN only).

## Operation
- MODE encodings: 0 = BARE, 1 = SMMPT43, 2 = SMMPT52, 3 = SMMPT64, 4..15 = reserved.
- Format check on the granted channel:
  - BARE: NOT_VALID_ADDR.
  - SMMPT43: NOT_VALID_ADDR if spa[63:43] != 0.
  - SMMPT52: NOT_VALID_ADDR if spa[63:52] != 0.
  - SMMPT64: NO_ERROR.
  - Reserved: NOT_VALID_ADDR.
- m_walking_o = (fault == NO_ERROR).
- Arbitration: round-robin priority pointer rr_q. The grant goes to the first valid channel at or after rr_q, wrapping modulo NUM_CH.
- On acceptance of channel k, rr_q <= (k+1) mod NUM_CH. rr_q holds when nothing is accepted.
- Acceptance condition: ch_ready_o[k] = grant[k] && count_q != 2 && !flush_i. Acceptance = ch_valid_i[k] && ch_ready_o[k].
- ch_ready_o does not depend on m_ready_i.
- FIFO: 2 entries, count_q in {0,1,2}.
  - Push on acceptance; pop on m_valid_o && m_ready_i.
  - Simultaneous push and pop keeps count_q unchanged, and order is preserved.
  - m_valid_o = (count_q != 0). Outputs always show the head entry.
- Flush: count_q <= 0 and the FIFO contents are discarded. No acceptance and no exception occur in the flush cycle. rr_q and counters are unaffected.
- Exceptions: exc_valid_o is registered high for exactly one cycle after a faulting transaction is accepted, independent of m_ready_i. exc_ch_o and exc_cause_o are valid with it and hold their last value otherwise.
- Reset values: count_q = 0, rr_q = 0, m_valid_o = 0, exc_valid_o = 0, exc_ch_o = 0, exc_cause_o = 0, err_cnt_o = 0. Data outputs are 0 while the FIFO is empty after reset.
- Reset mid-operation drops all buffered transactions; no m_valid_o is asserted in the cycle following reset.

## Timing
- Latency: a transaction accepted at edge N appears on m_valid_o after edge N (one cycle).
- Throughput: one transaction per cycle while m_ready_i is held high.
- With m_ready_i low: at most 2 transactions are accepted, then all ch_ready_o deassert.
- With m_ready_i held high and one channel continuously valid: that channel is accepted every cycle.
- With all NUM_CH channels continuously valid: each channel is granted once every NUM_CH accepted transactions.
- exc_valid_o asserts in the same cycle that the faulting transaction first becomes visible at the FIFO output when the FIFO was empty; otherwise it asserts earlier than the entry reaches the head.

## Configuration
- MPT_FETCH_ERR_CNT_EN defined: NUM_CH counters of CNT_WIDTH bits, exposed on err_cnt_o.
  - Counter k increments by 1 per accepted faulting transaction from channel k.
  - Counters saturate at all-ones and clear only on rst_i.
- MPT_FETCH_ERR_CNT_EN undefined: err_cnt_o port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle: all outputs 0 and all ch_ready_o 0. Channel 2 with SMMPT64 and spa = 0xFFFF_0000_0000_1000 -> next cycle m_valid_o = 1, m_ch_o = 2, m_walking_o = 1, m_fault_o = 0.
- Mode checks on channel 0: SMMPT43 with spa = 1<<43, SMMPT52 with spa = 1<<52, BARE, and MODE = 7 -> each gives m_fault_o = 1, m_walking_o = 0, and an exc_valid_o pulse with exc_ch_o = 0. SMMPT52 with spa = 1<<51 -> no fault.
- All 4 channels valid continuously with m_ready_i = 1 -> grant order 0, 1, 2, 3, 0, ...; one acceptance per cycle.
- m_ready_i = 0 and channels 1 and 3 valid -> two acceptances (1 then 3), then ch_ready_o = 0. Raise m_ready_i -> outputs pop in order 1, 3.
- FIFO holding 2 entries, flush_i pulsed with channel 0 valid and faulting -> m_valid_o = 0 next cycle, no exc_valid_o, channel 0 accepted in the following cycle.
- With MPT_FETCH_ERR_CNT_EN and CNT_WIDTH = 2: 5 faulting transactions on channel 1 -> counter 1 reads 3 (saturated), other counters read 0.
